seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the multiplexed 7-segment display driver. It samples the scanned anode/cathode lines (Cnode, AN, dp) and reconstructs the displayed 32-bit hex word, one nibble per digit. It completes a frame once all eight digits have been captured. The block sits on the board loopback path and in benches to check what the counter/display chain actually shows.

## Interface
Parameters:
- SETTLE, 4: consecutive cycles a synchronized {AN, Cnode, dp} pattern must stay unchanged before capture (≥1).
- TIMEOUT, 2_000_000: cycles without a completed frame before `stale` asserts.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-low reset.
- AN  input  8  digit anodes, active-low; AN[i] low selects digit i.
- Cnode  input  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  input  1  decimal point, active-low.
- digits  output  32  decoded word; digit i → digits[4i+3:4i].
- bad_mask  output  8  bit i set: digit i pattern not a legal hex glyph.
- dp_mask  output  8  bit i set: dp lit on digit i (see Configuration).
- frame_valid  output  1  one-cycle pulse when digits/bad_mask/dp_mask update.
- stale  output  1  no frame completed within TIMEOUT cycles.

## Operation
- AN, Cnode and dp each pass through a 2-flop synchronizer.
- Stability counter: increments while the synchronized {AN, Cnode, dp} equals the previous cycle's value. Any change reloads it to 0. The counter saturates at SETTLE.
- Capture fires once per dwell, on the cycle the counter reaches SETTLE, and only if AN is one-hot-low (exactly one bit 0).
  - AN all-high or multi-hot-low: no capture, no error.
- Capture of digit i: pattern decoded to a nibble into staging[i]; seen[i]=1.
  - Legal glyphs: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh.
  - Any other pattern: nibble 0, stage_bad[i]=1.
- Re-capture of an already-seen digit before the frame completes overwrites its staging entry.
- Frame complete when seen==FFh:
  - next cycle, digits/bad_mask/dp_mask load from staging;
  - frame_valid=1 for that cycle;
  - seen clears in the same cycle.
- Scan order and direction are irrelevant; only coverage of all eight digits matters.
- Timeout counter: cleared on frame_valid, otherwise increments and saturates. stale=1 while the count ≥ TIMEOUT; it clears on the frame_valid cycle.

## Timing
- Reset (async assert, sync release): digits=0, bad_mask=0, dp_mask=0, frame_valid=0, stale=0; seen, staging, stability and timeout counters all 0.
- Latency from raw input change to capture: 2 (sync) + SETTLE cycles.
- Latency from eighth capture to frame_valid: 1 cycle.
- Eighth capture and an AN change in the same cycle: the capture wins; the next dwell starts the new frame.
- Reset mid-frame discards the partial frame; there is no output until a full fresh frame.
- Outputs hold their last frame between frame_valid pulses.

## Configuration
- SEG7_SCAN_DEC_DP_EN defined: dp is synchronized and takes part in stability, and dp_mask[i] captures the inverted dp for digit i.
- Macro undefined: the dp input is ignored (no flops) and dp_mask is tied to 0.

## Structure
- Shared package seg7_pkg holds:
  - the sixteen active-low glyph constants;
  - the segment bit-order definition;
  - the NUM_DIGITS=8 constant.
- Sub-module seg7_glyph_decode: combinational 7-bit pattern → {legal, nibble[3:0]}, instantiated once in the capture path. The display-side encoder shares the same package constants.

## Test plan
- Scan digits 0..7 with glyphs 0..7 (AN=FEh..7Fh), each dwell 10 cycles, SETTLE=4 → digits=76543210h, bad_mask=00h, exactly one frame_valid, 1 cycle after the digit-7 capture.
- Reverse scan 7..0 showing word DEADBEEFh → digits=DEADBEEFh on the frame_valid.
- Digit 3 driven with 7Fh (blank) → bad_mask=08h, nibble 3 = 0, other nibbles correct.
- Dwells of SETTLE-1 cycles only → no capture, no frame_valid. Also AN=FCh (two digits low) for 20 cycles → no capture.
- Assert rst after 5 digits are captured, then release and scan a full frame → the first frame_valid carries only post-reset data. Hold inputs static for TIMEOUT cycles → stale=1; the next frame_valid clears it.
- With SEG7_SCAN_DEC_DP_EN, dp low on digit 2 → dp_mask=04h. Without the macro → dp_mask=00h.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, active-low glyph constants and digit count.
// Used by both the display-side encoder and the scan-side decoder.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_IW   = $clog2(NUM_DIGITS);

    // Segment bit positions within a 7-bit pattern {g,f,e,d,c,b,a}; a segment is lit when its bit is 0.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0: pattern = GLYPH_0;
            4'h1: pattern = GLYPH_1;
            4'h2: pattern = GLYPH_2;
            4'h3: pattern = GLYPH_3;
            4'h4: pattern = GLYPH_4;
            4'h5: pattern = GLYPH_5;
            4'h6: pattern = GLYPH_6;
            4'h7: pattern = GLYPH_7;
            4'h8: pattern = GLYPH_8;
            4'h9: pattern = GLYPH_9;
            4'hA: pattern = GLYPH_A;
            4'hB: pattern = GLYPH_B;
            4'hC: pattern = GLYPH_C;
            4'hD: pattern = GLYPH_D;
            4'hE: pattern = GLYPH_E;
            default: pattern = GLYPH_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of seg7_encode: maps an active-low segment pattern to {legal, nibble}.
// Patterns that are not one of the sixteen hex glyphs return legal=0 and nibble=0.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (pattern)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment scan (AN/Cnode/dp) and rebuilds the displayed 32-bit hex word.
// Optional macro SEG7_SCAN_DEC_DP_EN enables decimal-point capture into dp_mask.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 2_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS-1:0]     AN,
    input  logic [6:0]                Cnode,
    input  logic                      dp,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     bad_mask,
    output logic [NUM_DIGITS-1:0]     dp_mask,
    output logic                      frame_valid,
    output logic                      stale
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    logic [NUM_DIGITS-1:0] an_s1, an_s2, an_p;
    logic [6:0]            cn_s1, cn_s2, cn_p;
    logic                  dp_same;
    logic [SW-1:0]         stab;
    logic                  same, capture;
    logic [DIGIT_IW-1:0]   idx;
    logic                  glyph_legal;
    logic [3:0]            glyph_nibble;
    logic [4*NUM_DIGITS-1:0] stage_word;
    logic [NUM_DIGITS-1:0] stage_bad, seen, seen_set;
    logic                  frame_done;
    logic [TW-1:0]         tcnt;

    // Synchronizers and the previous-cycle copy idle at the inactive (all-high) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_s1 <= '1;
            an_s2 <= '1;
            an_p  <= '1;
            cn_s1 <= '1;
            cn_s2 <= '1;
            cn_p  <= '1;
        end else begin
            an_s1 <= AN;
            an_s2 <= an_s1;
            an_p  <= an_s2;
            cn_s1 <= Cnode;
            cn_s2 <= cn_s1;
            cn_p  <= cn_s2;
        end
    end

`ifdef SEG7_SCAN_DEC_DP_EN
    logic                  dp_s1, dp_s2, dp_p;
    logic [NUM_DIGITS-1:0] stage_dp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_s1    <= 1'b1;
            dp_s2    <= 1'b1;
            dp_p     <= 1'b1;
            stage_dp <= '0;
            dp_mask  <= '0;
        end else begin
            dp_s1 <= dp;
            dp_s2 <= dp_s1;
            dp_p  <= dp_s2;
            if (capture)
                stage_dp[idx] <= ~dp_s2;
            if (frame_done)
                dp_mask <= stage_dp;
        end
    end

    assign dp_same = (dp_s2 == dp_p);
`else
    logic unused_dp;
    assign unused_dp = dp;
    assign dp_same   = 1'b1;
    assign dp_mask   = '0;
`endif

    assign same = (an_s2 == an_p) && (cn_s2 == cn_p) && dp_same;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stab <= '0;
        else if (!same)
            stab <= '0;
        else if (stab != SETTLE_C)
            stab <= stab + 1'b1;
    end

    // Fires only on the step into SETTLE, so a long dwell captures exactly once.
    assign capture = same && (stab == SETTLE_C - SW'(1)) && $onehot(~an_s2);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!an_s2[i])
                idx = DIGIT_IW'(i);
    end

    seg7_glyph_decode u_glyph_decode (
        .pattern (cn_s2),
        .legal   (glyph_legal),
        .nibble  (glyph_nibble)
    );

    assign frame_done = &seen;
    assign seen_set   = capture ? ~an_s2 : '0;

    // A capture in the completing cycle starts the next frame rather than being lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_word <= '0;
            stage_bad  <= '0;
            seen       <= '0;
        end else begin
            if (capture) begin
                stage_word[{idx, 2'b00} +: 4] <= glyph_nibble;
                stage_bad[idx]                <= ~glyph_legal;
            end
            seen <= (frame_done ? '0 : seen) | seen_set;
        end
    end

    // frame_valid is a one-cycle strobe with no back-pressure: digits/bad_mask/dp_mask are
    // new in the strobe cycle and hold until the next strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits      <= '0;
            bad_mask    <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                digits   <= stage_word;
                bad_mask <= stage_bad;
            end
        end
    end

    // Cleared on the edge that raises frame_valid so stale is already low in that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tcnt <= '0;
        else if (frame_done)
            tcnt <= '0;
        else if (tcnt != TIMEOUT_C)
            tcnt <= tcnt + 1'b1;
    end

    assign stale = (tcnt == TIMEOUT_C);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans, bad glyphs, short dwells, reset, timeout, dp.
module tb_seg7_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AN;
    logic [6:0]  Cnode;
    logic        dp;
    logic [31:0] digits;
    logic [7:0]  bad_mask;
    logic [7:0]  dp_mask;
    logic        frame_valid;
    logic        stale;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .AN          (AN),
        .Cnode       (Cnode),
        .dp          (dp),
        .digits      (digits),
        .bad_mask    (bad_mask),
        .dp_mask     (dp_mask),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    int total = 0;
    int bad   = 0;

    int          fv_count = 0;
    logic [31:0] fv_digits = '0;
    logic [7:0]  fv_bad = '0;
    logic [7:0]  fv_dp = '0;
    logic        fv_stale = 1'b0;

    logic [6:0] glyph [16];

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count  <= fv_count + 1;
            fv_digits <= digits;
            fv_bad    <= bad_mask;
            fv_dp     <= dp_mask;
            fv_stale  <= stale;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dwell(input logic [7:0] an_v, input logic [6:0] cn_v, input logic dp_v,
                         input int cycles);
        AN    = an_v;
        Cnode = cn_v;
        dp    = dp_v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic show(input int d, input logic [3:0] nib, input int cycles);
        dwell(~(8'd1 << d), glyph[nib], 1'b1, cycles);
    endtask

    task automatic idle(input int cycles);
        dwell(8'hFF, 7'h7F, 1'b1, cycles);
    endtask

    initial begin
        logic [31:0] word;
        logic [7:0]  exp_dp;

        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef SEG7_SCAN_DEC_DP_EN
        exp_dp = 8'h04;
`else
        exp_dp = 8'h00;
`endif

        // Reset state
        rst = 1'b0;
        AN = 8'hFF; Cnode = 7'h7F; dp = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_digits", digits, 32'h0);
        check("rst_bad_mask", 32'(bad_mask), 32'h0);
        check("rst_dp_mask", 32'(dp_mask), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Forward scan 0..7 showing glyphs 0..7
        for (int d = 0; d < 7; d++) show(d, 4'(d), 10);
        check("fwd_no_early_frame", 32'(fv_count), 32'd0);
        show(7, 4'h7, 10);
        check("fwd_frame_in_last_dwell", 32'(fv_count), 32'd1);
        idle(10);
        check("fwd_single_frame", 32'(fv_count), 32'd1);
        check("fwd_fv_digits", fv_digits, 32'h76543210);
        check("fwd_digits_hold", digits, 32'h76543210);
        check("fwd_bad_mask", 32'(fv_bad), 32'h0);
        check("fwd_dp_mask", 32'(fv_dp), 32'h0);
        check("fwd_stale", 32'(stale), 32'h0);

        // Reverse scan 7..0 showing DEADBEEF
        word = 32'hDEADBEEF;
        for (int d = 7; d >= 0; d--) show(d, word[4*d +: 4], 10);
        idle(10);
        check("rev_frame_count", 32'(fv_count), 32'd2);
        check("rev_digits", fv_digits, 32'hDEADBEEF);
        check("rev_bad_mask", 32'(fv_bad), 32'h0);

        // Digit 3 blank -> illegal glyph
        for (int d = 0; d < 8; d++) begin
            if (d == 3) dwell(~(8'd1 << d), 7'h7F, 1'b1, 10);
            else        show(d, 4'(d), 10);
        end
        idle(10);
        check("badglyph_frame_count", 32'(fv_count), 32'd3);
        check("badglyph_digits", fv_digits, 32'h76540210);
        check("badglyph_bad_mask", 32'(fv_bad), 32'h08);

        // Dwells of SETTLE-1 cycles and a two-hot AN must not capture
        for (int d = 0; d < 8; d++) show(d, 4'h8, SETTLE - 1);
        dwell(8'hFC, glyph[8], 1'b1, 20);
        idle(10);
        check("short_dwell_no_frame", 32'(fv_count), 32'd3);
        for (int d = 1; d < 8; d++) show(d, 4'h8, 10);
        idle(10);
        check("multi_hot_no_capture", 32'(fv_count), 32'd3);
        show(0, 4'h5, 10);
        idle(10);
        check("after_multi_hot_frame", 32'(fv_count), 32'd4);
        check("after_multi_hot_digits", fv_digits, 32'h88888885);

        // Reset after five captures discards the partial frame
        for (int d = 0; d < 5; d++) show(d, 4'h9, 10);
        rst = 1'b0;
        idle(3);
        check("midrst_digits", digits, 32'h0);
        check("midrst_frame_valid", 32'(frame_valid), 32'h0);
        check("midrst_bad_mask", 32'(bad_mask), 32'h0);
        rst = 1'b1;
        idle(2);
        for (int d = 5; d < 8; d++) show(d, 4'hC, 10);
        idle(10);
        check("midrst_partial_discard", 32'(fv_count), 32'd4);
        for (int d = 0; d < 5; d++) show(d, 4'h1, 10);
        idle(10);
        check("midrst_frame_count", 32'(fv_count), 32'd5);
        check("midrst_fresh_digits", fv_digits, 32'hCCC11111);

        // Timeout: no frame for TIMEOUT cycles
        idle(250);
        check("stale_before_timeout", 32'(stale), 32'h0);
        idle(60);
        check("stale_after_timeout", 32'(stale), 32'h1);

        // Frame with dp lit on digit 2 clears stale
        for (int d = 0; d < 8; d++)
            dwell(~(8'd1 << d), glyph[d], (d == 2) ? 1'b0 : 1'b1, 10);
        idle(10);
        check("dp_frame_count", 32'(fv_count), 32'd6);
        check("dp_fv_stale", 32'(fv_stale), 32'h0);
        check("dp_stale_after", 32'(stale), 32'h0);
        check("dp_digits", fv_digits, 32'h76543210);
        check("dp_mask", 32'(fv_dp), 32'(exp_dp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
